// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared types and widths for the SPI transaction arbiter
package spi_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_START,
        ST_WAIT,
        ST_DONE
    } arb_state_e;

    localparam int TRANS_CTRL_W = 32;
    localparam int MAX_REQ      = 8;
    // ptr/owner are sized for the largest supported requester count
    localparam int PTR_W        = $clog2(MAX_REQ);

endpackage

// File: rtl/spi_arb_rr_pick.sv
// rtl/spi_arb_rr_pick.sv - combinational round-robin picker, first set request at or after ptr
module spi_arb_rr_pick
    import spi_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic             valid_o,
    output logic [PTR_W-1:0] owner_o
);

    logic [MAX_REQ-1:0] req_pad;
    assign req_pad = MAX_REQ'(req_i);

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int off);
        int s;
        s = int'(p) + off;
        if (s >= N) begin
            s = s - N;
        end
        return PTR_W'(s);
    endfunction

    // Scan from the farthest offset down so the nearest hit wins
    always_comb begin
        valid_o = 1'b0;
        owner_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_pad[wrap_add(ptr_i, i)]) begin
                valid_o = 1'b1;
                owner_o = wrap_add(ptr_i, i);
            end
        end
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// rtl/spi_txn_arbiter.sv - round-robin owner arbitration and start/done sequencing for the SPI master
// Optional watchdog on the WAIT state: define SPI_ARB_TIMEOUT_EN.
module spi_txn_arbiter
    import spi_arb_pkg::*;
#(
    parameter int g_num_req        = 4,
    parameter int g_timeout_cycles = 4096
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic [g_num_req-1:0]              req_i,
    input  logic [g_num_req-1:0]              lock_i,
    input  logic [TRANS_CTRL_W*g_num_req-1:0] req_ctrl_i,
    output logic [g_num_req-1:0]              gnt_o,
    output logic [g_num_req-1:0]              done_o,
    output logic [g_num_req-1:0]              err_o,
    output logic [TRANS_CTRL_W-1:0]           trans_ctrl_o,
    output logic                              trans_start_o,
    input  logic                              trans_done_i,
    output logic                              spi_busy_o
);

    arb_state_e                state_q;
    logic [PTR_W-1:0]          ptr_q;
    logic [PTR_W-1:0]          owner_q;
    logic [g_num_req-1:0]      gnt_q;
    logic [g_num_req-1:0]      done_q;
    logic [g_num_req-1:0]      err_q;
    logic [TRANS_CTRL_W-1:0]   trans_ctrl_q;
    logic                      trans_start_q;

    logic                      pick_valid;
    logic [PTR_W-1:0]          pick_owner;
    logic [g_num_req-1:0]      pick_oh;
    logic [g_num_req-1:0]      owner_oh;
    logic [MAX_REQ-1:0]        req_pad;
    logic [MAX_REQ-1:0]        lock_pad;
    logic [TRANS_CTRL_W-1:0]   ctrl_word [MAX_REQ];

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(g_timeout_cycles + 1);
    logic [TO_W-1:0] to_cnt_q;
`endif

    spi_arb_rr_pick #(
        .N(g_num_req)
    ) u_pick (
        .req_i  (req_i),
        .ptr_i  (ptr_q),
        .valid_o(pick_valid),
        .owner_o(pick_owner)
    );

    for (genvar k = 0; k < MAX_REQ; k++) begin : g_ctrl
        if (k < g_num_req) begin : g_used
            assign ctrl_word[k] = req_ctrl_i[TRANS_CTRL_W*k +: TRANS_CTRL_W];
        end else begin : g_unused
            assign ctrl_word[k] = '0;
        end
    end

    assign req_pad  = MAX_REQ'(req_i);
    assign lock_pad = MAX_REQ'(lock_i);
    assign pick_oh  = g_num_req'(1) << pick_owner;
    assign owner_oh = g_num_req'(1) << owner_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            owner_q       <= '0;
            gnt_q         <= '0;
            done_q        <= '0;
            err_q         <= '0;
            trans_ctrl_q  <= '0;
            trans_start_q <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            to_cnt_q      <= '0;
`endif
        end else begin
            done_q        <= '0;
            err_q         <= '0;
            trans_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        owner_q      <= pick_owner;
                        gnt_q        <= pick_oh;
                        trans_ctrl_q <= ctrl_word[pick_owner];
                        state_q      <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    trans_start_q <= 1'b1;
                    state_q       <= ST_START;
                end
                ST_START: begin
`ifdef SPI_ARB_TIMEOUT_EN
                    to_cnt_q <= '0;
`endif
                    state_q  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (trans_done_i) begin
                        done_q  <= owner_oh;
                        state_q <= ST_DONE;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    else if (to_cnt_q == TO_W'(g_timeout_cycles - 1)) begin
                        err_q   <= owner_oh;
                        state_q <= ST_DONE;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
`endif
                end
                ST_DONE: begin
                    // err_q is only high in DONE after a timeout, which voids the lock
                    if (err_q == '0 && lock_pad[owner_q] && req_pad[owner_q]) begin
                        trans_ctrl_q  <= ctrl_word[owner_q];
                        trans_start_q <= 1'b1;
                        state_q       <= ST_START;
                    end else begin
                        gnt_q   <= '0;
                        ptr_q   <= (owner_q == PTR_W'(g_num_req - 1)) ? '0 : owner_q + PTR_W'(1);
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign gnt_o         = gnt_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign trans_ctrl_o  = trans_ctrl_q;
    assign trans_start_o = trans_start_q;
    assign spi_busy_o    = (state_q != ST_IDLE);

endmodule
